// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: op-field encoding, FSM states
// and the byte/half lane extract and merge helpers.
package mem_pkg;

  localparam int         OP_WRITE_BIT = 2;
  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_BAD     = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  // Pull the addressed lane out of a word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SIZE_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of a word with the right-justified store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size);
    logic [31:0] r;
    r = word;
    case (size)
      SIZE_BYTE: begin
        case (off)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_sram_bank.sv
// Word-wide synchronous SRAM bank. Reads return data LATENCY clocks after the
// address is presented; writes land on the edge where we is high.
module mem_sram_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_reg  [DEPTH_WORDS];
  logic [31:0] pipe_reg [LATENCY];

  // First stage is the registered array read; the rest model access delay.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[addr] <= wdata;
    end
    pipe_reg[0] <= mem_reg[addr];
    for (int i = 1; i < LATENCY; i++) begin
      pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign rdata = pipe_reg[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side target servicing load/store/fetch requests over valid/ready
// channels, with read-modify-write for sub-word stores and fault reporting.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam int          CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          write_reg, write_next;
  logic [1:0]    size_reg, size_next;
  logic          uns_reg, uns_next;
  logic [1:0]    off_reg, off_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic          fault_reg, fault_next;

  logic [31:0]   req_offset;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_fault;

  logic [AW-1:0] sram_addr;
  logic          sram_we;
  logic [31:0]   sram_rdata;

  assign req_offset = req_addr - BASE_ADDR;
  assign req_write  = req_op[OP_WRITE_BIT];
  assign req_size   = req_op[1:0];

  always_comb begin
    req_fault = 1'b0;
    if (req_size == SIZE_BAD)                              req_fault = 1'b1;
    if (req_size == SIZE_HALF && req_offset[0] != 1'b0)    req_fault = 1'b1;
    if (req_size == SIZE_WORD && req_offset[1:0] != 2'b00) req_fault = 1'b1;
    if ({1'b0, req_offset} >= SPAN)                        req_fault = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    write_next = write_reg;
    size_next  = size_reg;
    uns_next   = uns_reg;
    off_next   = off_reg;
    idx_next   = idx_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    fault_next = fault_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    sram_addr  = idx_reg;
    sram_we    = 1'b0;

    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        // Present the incoming index early so read data is ready on time.
        sram_addr = req_offset[AW+1:2];
        if (req_valid) begin
          write_next = req_write;
          size_next  = req_size;
          uns_next   = req_unsigned;
          off_next   = req_offset[1:0];
          idx_next   = req_offset[AW+1:2];
          wdata_next = req_wdata;
          rdata_next = 32'h0;
          fault_next = req_fault;
          cnt_next   = CNT_LOAD;
          if (req_fault)                             state_next = RESP;
          else if (req_write && req_size == SIZE_WORD) state_next = WR;
          else                                         state_next = RD;
        end
      end
      RD: begin
        if (cnt_reg == '0) begin
          if (write_reg) begin
            wdata_next = lane_merge(sram_rdata, wdata_reg, off_reg, size_reg);
            cnt_next   = CNT_LOAD;
            state_next = WR;
          end else begin
            rdata_next = lane_extract(sram_rdata, off_reg, size_reg, uns_reg);
            state_next = RESP;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      WR: begin
        if (cnt_reg == '0) begin
          // Commit only on the last cycle, and never on a reset edge.
          sram_we    = reset;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      write_reg <= 1'b0;
      size_reg  <= SIZE_WORD;
      uns_reg   <= 1'b0;
      off_reg   <= 2'b00;
      idx_reg   <= '0;
      wdata_reg <= 32'h0;
      rdata_reg <= 32'h0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      write_reg <= write_next;
      size_reg  <= size_next;
      uns_reg   <= uns_next;
      off_reg   <= off_next;
      idx_reg   <= idx_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      fault_reg <= fault_next;
    end
  end

  assign resp_rdata = rdata_reg;
  assign resp_fault = fault_reg;

  mem_sram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LATENCY     (LATENCY)
  ) u_bank (
    .clk   (clk),
    .addr  (sram_addr),
    .we    (sram_we),
    .wdata (wdata_reg),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table of vectors, backpressure,
// mid-operation reset and back-to-back random SW/LW pairs.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  mem_responder #(
    .DEPTH_WORDS (1024),
    .LATENCY     (2),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic add_vec(string name, logic [2:0] op, logic uns, logic [31:0] addr,
                         logic [31:0] wdata, logic [31:0] exp_rdata, logic exp_fault,
                         int exp_lat);
    vec_t v;
    v.name = name; v.op = op; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_fault = exp_fault; v.exp_lat = exp_lat;
    vecs.push_back(v);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge after the
  // response handshake. hold > 0 keeps resp_ready low for that many cycles.
  task automatic do_req(string name, logic [2:0] op, logic uns, logic [31:0] addr,
                        logic [31:0] wdata, logic [31:0] exp_rdata, logic exp_fault,
                        int exp_lat, int hold);
    exp_t e;
    int   lat;
    check({name, ".req_ready"}, 32'(req_ready), 32'd1);
    e.rdata = exp_rdata; e.fault = exp_fault; e.lat = exp_lat;
    sb_q.push_back(e);
    req_valid    = 1'b1;
    req_op       = op;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    resp_ready   = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'h5A5A_5A5A;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 40);
    e = sb_q.pop_front();
    check({name, ".resp_valid"}, 32'(resp_valid), 32'd1);
    check({name, ".latency"}, 32'(lat), 32'(e.lat));
    check({name, ".rdata"}, resp_rdata, e.rdata);
    check({name, ".fault"}, 32'(resp_fault), 32'(e.fault));
    $display("txn %s op=%b uns=%b addr=%h wdata=%h rdata=%h fault=%b lat=%0d",
             name, op, uns, addr, wdata, resp_rdata, resp_fault, lat);
    if (hold > 0) begin
      // A competing store that must be ignored while the response is pending.
      req_valid = 1'b1;
      req_op    = 3'b110;
      req_wdata = 32'hDEAD_BEEF;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({name, ".hold_valid"}, 32'(resp_valid), 32'd1);
        check({name, ".hold_rdata"}, resp_rdata, e.rdata);
        check({name, ".hold_fault"}, 32'(resp_fault), 32'(e.fault));
        check({name, ".hold_req_ready"}, 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({name, ".post_resp_valid"}, 32'(resp_valid), 32'd0);
    check({name, ".post_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic check_reset_state(string name);
    check({name, ".req_ready"}, 32'(req_ready), 32'd1);
    check({name, ".resp_valid"}, 32'(resp_valid), 32'd0);
    check({name, ".rdata"}, resp_rdata, 32'h0);
    check({name, ".fault"}, 32'(resp_fault), 32'd0);
  endtask

  // Accept a request, then pull reset low after `delay` cycles into the op.
  task automatic abort_req(string name, logic [2:0] op, logic [31:0] addr,
                           logic [31:0] wdata, int delay);
    req_valid = 1'b1;
    req_op    = op;
    req_unsigned = 1'b0;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < delay; i++) @(negedge clk);
    check({name, ".busy_req_ready"}, 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_reset_state(name);
    $display("txn %s aborted op=%b addr=%h", name, op, addr);
  endtask

  logic [31:0] model [int];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_op       = 3'b010;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    resp_ready   = 1'b1;

    add_vec("sw_100",     3'b110, 0, 32'h100, 32'h1122_3344, 32'h0,         0, 3);
    add_vec("lw_100",     3'b010, 0, 32'h100, 32'h0,         32'h1122_3344, 0, 3);
    add_vec("sb_103",     3'b100, 0, 32'h103, 32'h0000_00AB, 32'h0,         0, 5);
    add_vec("lw_100_b",   3'b010, 0, 32'h100, 32'h0,         32'hAB22_3344, 0, 3);
    add_vec("lb_103",     3'b000, 0, 32'h103, 32'h0,         32'hFFFF_FFAB, 0, 3);
    add_vec("lbu_103",    3'b000, 1, 32'h103, 32'h0,         32'h0000_00AB, 0, 3);
    add_vec("lhu_102",    3'b001, 1, 32'h102, 32'h0,         32'h0000_AB22, 0, 3);
    add_vec("lw_102_mis", 3'b010, 0, 32'h102, 32'h0,         32'h0,         1, 1);
    add_vec("sh_101_mis", 3'b101, 0, 32'h101, 32'h0000_FFFF, 32'h0,         1, 1);
    add_vec("lw_100_c",   3'b010, 0, 32'h100, 32'h0,         32'hAB22_3344, 0, 3);
    add_vec("bad_size",   3'b011, 0, 32'h100, 32'h0,         32'h0,         1, 1);
    add_vec("lw_oor",     3'b010, 0, 32'h1000, 32'h0,        32'h0,         1, 1);
    add_vec("sw_200",     3'b110, 0, 32'h200, 32'h8000_7FFF, 32'h0,         0, 3);
    add_vec("sh_202",     3'b101, 0, 32'h202, 32'h0000_FEDC, 32'h0,         0, 5);
    add_vec("lw_200",     3'b010, 0, 32'h200, 32'h0,         32'hFEDC_7FFF, 0, 3);
    add_vec("lh_202",     3'b001, 0, 32'h202, 32'h0,         32'hFFFF_FEDC, 0, 3);
    add_vec("lhu_202",    3'b001, 1, 32'h202, 32'h0,         32'h0000_FEDC, 0, 3);
    add_vec("lb_201",     3'b000, 0, 32'h201, 32'h0,         32'h0000_007F, 0, 3);
    add_vec("lb_200",     3'b000, 0, 32'h200, 32'h0,         32'hFFFF_FFFF, 0, 3);
    add_vec("lh_200",     3'b001, 0, 32'h200, 32'h0,         32'h0000_7FFF, 0, 3);
    add_vec("sw_ffc",     3'b110, 0, 32'hFFC, 32'hCAFE_F00D, 32'h0,         0, 3);
    add_vec("sb_ffe",     3'b100, 0, 32'hFFE, 32'h0000_0012, 32'h0,         0, 5);
    add_vec("lw_ffc",     3'b010, 0, 32'hFFC, 32'h0,         32'hCA12_F00D, 0, 3);
    add_vec("lb_fff",     3'b000, 0, 32'hFFF, 32'h0,         32'hFFFF_FFCA, 0, 3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_reset_state("reset");

    foreach (vecs[i]) begin
      do_req(vecs[i].name, vecs[i].op, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_fault, vecs[i].exp_lat, 0);
    end

    do_req("lw_backpressure", 3'b010, 0, 32'h100, 32'h0, 32'hAB22_3344, 0, 3, 5);
    do_req("lw_after_bp", 3'b010, 0, 32'h100, 32'h0, 32'hAB22_3344, 0, 3, 0);

    abort_req("abort_sb_rd", 3'b100, 32'h100, 32'h0000_00FF, 1);
    do_req("lw_after_abort_rd", 3'b010, 0, 32'h100, 32'h0, 32'hAB22_3344, 0, 3, 0);
    abort_req("abort_sw_wr", 3'b110, 32'h100, 32'h0000_0000, 1);
    do_req("lw_after_abort_wr", 3'b010, 0, 32'h100, 32'h0, 32'hAB22_3344, 0, 3, 0);

    for (int p = 0; p < 8; p++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = 32'($urandom_range(0, 1023)) << 2;
      d = $urandom;
      model[int'(a)] = d;
      do_req($sformatf("b2b_sw_%0d", p), 3'b110, 0, a, d, 32'h0, 0, 3, 0);
      do_req($sformatf("b2b_lw_%0d", p), 3'b010, 0, a, 32'h0, model[int'(a)], 0, 3, 0);
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side target that services the core's load, store and fetch requests over a valid/ready request channel and a valid/ready response channel.
- Backed by a word-wide synchronous SRAM bank with configurable access latency.
- Sub-word stores use read-modify-write; sub-word loads are sign- or zero-extended.
- Misaligned, out-of-range and invalid-size accesses are reported on a fault line, which the core ORs into its global fault.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the bank (power of two).
- LATENCY, 2, SRAM access latency in cycles; must be >= 1.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-low: 0 = reset, sampled on the posedge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_op  in  3  {write, size[1:0]}; size 00 = byte, 01 = half, 10 = word, 11 = invalid.
- req_unsigned  in  1  zero-extend sub-word loads; ignored for writes.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  32  load data; 0 for writes and faults.
- resp_fault  out  1  access faulted.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - state <= IDLE; req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_fault = 0.
  - Any in-flight operation is aborted. SRAM contents are not cleared.
- States: IDLE, RD (read phase), WR (write phase), RESP.
- IDLE:
  - req_ready = 1 only in IDLE.
  - Accept at the edge where req_valid & req_ready; latch op, unsigned flag, addr and wdata.
  - A fault is detected at accept if any of the following hold:
    - size == 11;
    - half with addr[0] != 0;
    - word with addr[1:0] != 0;
    - (addr - BASE_ADDR) >= DEPTH_WORDS*4, compared unsigned.
  - On fault: go to RESP with resp_fault = 1 and rdata = 0. No SRAM access occurs.
  - Otherwise, a read or a sub-word write goes to RD, and a word write goes to WR.
- RD:
  - Issue the SRAM read at word index (addr - BASE_ADDR) >> 2.
  - A down-counter loaded with LATENCY-1 runs; at 0 the read data is valid.
  - For a load: select the byte or half lane from addr[1:0], sign- or zero-extend it, then go to RESP.
  - For a sub-word write: merge wdata[7:0] or wdata[15:0] into the selected lane of the read word, then go to WR.
- WR:
  - Drive the write for LATENCY cycles.
  - The write commits to the array only on the final WR cycle, so an abort before that point leaves memory unchanged.
  - Then go to RESP with rdata = 0.
- RESP:
  - resp_valid = 1; resp_rdata and resp_fault are held stable while resp_ready = 0.
  - On resp_valid & resp_ready, go to IDLE; req_ready rises the next cycle. There is no same-cycle back-to-back accept.
- Latency from the accept edge to resp_valid:
  - fault: 1 cycle;
  - load or word store: LATENCY+1 cycles;
  - sub-word store: 2*LATENCY+1 cycles.
- Lane order is little-endian:
  - byte lane k = bits [8k+7:8k];
  - half at addr[1] = 1 → bits [31:16].
- Request inputs are ignored outside IDLE.

Decomposition:
- Package mem_pkg holds:
  - op-field constants: OP_WRITE_BIT, SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - the state enum {IDLE, RD, WR, RESP};
  - lane extract/merge functions.
- Sub-module mem_sram_bank(clk, addr, we, wdata, rdata) holds the DEPTH_WORDS x 32 array with a LATENCY-stage read pipeline. The write occurs on the clock edge where we = 1.

Test Plan:
- Write/readback: SW 0x11223344 @0x100 → response after 3 cycles (LATENCY = 2), fault = 0; then LW @0x100 → rdata 0x11223344 after 3 cycles.
- Byte merge and extension: after the previous test, SB 0xAB @0x103 → response after 5 cycles.
  - LW @0x100 → 0xAB223344.
  - LB @0x103 → 0xFFFFFFAB.
  - LBU @0x103 → 0x000000AB.
  - LHU @0x102 → 0x0000AB22.
- Faults:
  - LW @0x102 → resp_fault = 1, rdata 0, response 1 cycle after accept.
  - SH @0x101 → fault, and a subsequent LW @0x100 is unchanged.
  - req_op = 3'b011 → fault.
  - LW @DEPTH_WORDS*4 → fault.
- Backpressure: LW with resp_ready held low for 5 cycles → resp_valid, rdata and fault stay stable; req_ready stays 0 even with req_valid high; IDLE is re-entered only after the handshake.
- Reset mid-op: assert reset = 0 during the RD phase of SB 0xFF @0x100 → next cycle req_ready = 1, resp_valid = 0; LW @0x100 still returns 0xAB223344.
- Back-to-back: 8 alternating SW/LW pairs to random aligned addresses with resp_ready = 1 → every read matches the scoreboard, and each accept occurs exactly one cycle after the previous response handshake.
